// File: rtl/timer_pkg.sv
// Shared definitions for the minutes:seconds timer: FSM state encoding and
// default stage terminal values.
package timer_pkg;

   localparam int SEC_MAX_DEF = 59;
   localparam int MIN_MAX_DEF = 99;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-(MAX+1) up/down counter stage with clear, clamped load and
// combinational terminal flags used for carry/borrow into the next stage.
module mod_updown_counter #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         step,
   input  logic         dir,
   output logic [W-1:0] cnt,
   output logic         at_max,
   output logic         at_zero
);

   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] ONE_V = W'(1);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_ld_clamped;

   assign w_ld_clamped = (ld_val > MAX_V) ? MAX_V : ld_val;
   assign at_max       = (r_cnt == MAX_V);
   assign at_zero      = (r_cnt == '0);
   assign cnt          = r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (ld) begin
         r_cnt <= w_ld_clamped;
      end else if (step) begin
         if (dir) r_cnt <= at_zero ? MAX_V : r_cnt - ONE_V;
         else     r_cnt <= at_max  ? '0    : r_cnt + ONE_V;
      end
   end

endmodule

// File: rtl/mmss_timer_core.sv
// Minutes:seconds timer core: cascaded second/minute stages advanced by a 1 Hz
// tick, run/pause/expire FSM, lap freeze of the displayed value and wrap pulse.
module mmss_timer_core
   import timer_pkg::*;
#(
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int MIN_MAX = MIN_MAX_DEF,
   parameter int SEC_W   = 6,
   parameter int MIN_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync_reset,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic             mode_down,
   input  logic             load,
   input  logic [MIN_W-1:0] load_min,
   input  logic [SEC_W-1:0] load_sec,
   input  logic             lap,
   output logic [SEC_W-1:0] sec_count,
   output logic [MIN_W-1:0] min_count,
   output logic [SEC_W-1:0] disp_sec,
   output logic [MIN_W-1:0] disp_min,
   output logic             lap_active,
   output logic             running,
   output logic             done,
   output logic             wrap
);

   state_t           r_state, w_state_nxt;
   logic             r_wrap, r_lap_active;
   logic [SEC_W-1:0] r_lap_sec;
   logic [MIN_W-1:0] r_lap_min;

   logic w_sec_max, w_sec_zero, w_min_max, w_min_zero, w_sec_one;
   logic w_step, w_at_origin, w_sec_step, w_min_step, w_expire, w_ld;

   // A tick only counts when nothing of higher priority claims the cycle.
   assign w_step      = tick && (r_state == ST_RUN) && !sync_reset && !load && !stop && !start;
   assign w_at_origin = w_sec_zero && w_min_zero;
   assign w_sec_step  = w_step && !(mode_down && w_at_origin);
   assign w_min_step  = w_sec_step && (mode_down ? w_sec_zero : w_sec_max);
   assign w_sec_one   = (sec_count == SEC_W'(1));
   assign w_expire    = w_step && mode_down && w_min_zero && (w_sec_one || w_sec_zero);
   assign w_ld        = load && !sync_reset;

   mod_updown_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
      .clk(clk), .rst(rst), .clr(sync_reset), .ld(w_ld), .ld_val(load_sec),
      .step(w_sec_step), .dir(mode_down),
      .cnt(sec_count), .at_max(w_sec_max), .at_zero(w_sec_zero)
   );

   mod_updown_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clk(clk), .rst(rst), .clr(sync_reset), .ld(w_ld), .ld_val(load_min),
      .step(w_min_step), .dir(mode_down),
      .cnt(min_count), .at_max(w_min_max), .at_zero(w_min_zero)
   );

   // NOTE: next-state defaults to the current state first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (sync_reset) begin
         w_state_nxt = ST_IDLE;
      end else if (load) begin
         if (r_state == ST_EXPIRED) w_state_nxt = ST_IDLE;
      end else if (stop) begin
         if (r_state == ST_RUN) w_state_nxt = ST_PAUSED;
      end else if (start) begin
         if (r_state == ST_IDLE || r_state == ST_PAUSED)
            w_state_nxt = (mode_down && w_at_origin) ? ST_EXPIRED : ST_RUN;
      end else if (w_expire) begin
         w_state_nxt = ST_EXPIRED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wrap       <= 1'b0;
         r_lap_active <= 1'b0;
         r_lap_sec    <= '0;
         r_lap_min    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wrap  <= w_sec_step && !mode_down && w_sec_max && w_min_max;
         if (sync_reset) begin
            r_lap_active <= 1'b0;
         end else if (lap) begin
            // Capture the pre-edge count, so a coincident tick is not included.
            if (!r_lap_active) begin
               r_lap_sec <= sec_count;
               r_lap_min <= min_count;
            end
            r_lap_active <= !r_lap_active;
         end
      end
   end

   assign disp_sec   = r_lap_active ? r_lap_sec : sec_count;
   assign disp_min   = r_lap_active ? r_lap_min : min_count;
   assign lap_active = r_lap_active;
   assign running    = (r_state == ST_RUN);
   assign done       = (r_state == ST_EXPIRED);
   assign wrap       = r_wrap;

endmodule

// File: tb/tb_mmss_timer_core.sv
// Scoreboard bench for mmss_timer_core: each stimulus cycle pushes the
// expected outputs, which are popped and compared once the edge has passed.
module tb_mmss_timer_core;

   localparam int SEC_W = 6;
   localparam int MIN_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sync_reset = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0;
   logic             mode_down = 1'b0, load = 1'b0, lap = 1'b0;
   logic [MIN_W-1:0] load_min = '0;
   logic [SEC_W-1:0] load_sec = '0;
   logic [SEC_W-1:0] sec_count, disp_sec;
   logic [MIN_W-1:0] min_count, disp_min;
   logic             lap_active, running, done, wrap;

   mmss_timer_core #(.SEC_MAX(59), .MIN_MAX(99), .SEC_W(SEC_W), .MIN_W(MIN_W)) dut (
      .clk(clk), .rst(rst), .sync_reset(sync_reset), .tick(tick),
      .start(start), .stop(stop), .mode_down(mode_down), .load(load),
      .load_min(load_min), .load_sec(load_sec), .lap(lap),
      .sec_count(sec_count), .min_count(min_count),
      .disp_sec(disp_sec), .disp_min(disp_min),
      .lap_active(lap_active), .running(running), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    min, sec, dmin, dsec, lap, run, done, wrap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int mn, input int sc, input int dmn,
                             input int dsc, input int lp, input int rn, input int dn, input int wr);
      exp_t e;
      e.tag = tag; e.min = mn; e.sec = sc; e.dmin = dmn; e.dsec = dsc;
      e.lap = lp; e.run = rn; e.done = dn; e.wrap = wr;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".min"},  32'(min_count),  e.min);
         check({e.tag, ".sec"},  32'(sec_count),  e.sec);
         check({e.tag, ".dmin"}, 32'(disp_min),   e.dmin);
         check({e.tag, ".dsec"}, 32'(disp_sec),   e.dsec);
         check({e.tag, ".lap"},  32'(lap_active), e.lap);
         check({e.tag, ".run"},  32'(running),    e.run);
         check({e.tag, ".done"}, 32'(done),       e.done);
         check({e.tag, ".wrap"}, 32'(wrap),       e.wrap);
      end
   endtask

   // One clock: inputs already set are sampled on the edge, pulses drop after it.
   task automatic step();
      @(posedge clk);
      #1;
      sync_reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; lap = 1'b0;
      compare_out();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no summary expected summary");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state while rst is held.
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      compare_out();
      rst = 1'b0;

      // Up-count rollover 99:59 -> 0:0 with a single-cycle wrap.
      load = 1'b1; load_min = 8'd99; load_sec = 6'd58;
      expect_out("up_load", 99, 58, 99, 58, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("up_start", 99, 58, 99, 58, 0, 1, 0, 0); step();
      tick = 1'b1;
      expect_out("up_t1", 99, 59, 99, 59, 0, 1, 0, 0); step();
      tick = 1'b1;
      expect_out("up_wrap", 0, 0, 0, 0, 0, 1, 0, 1); step();
      expect_out("up_wrap_end", 0, 0, 0, 0, 0, 1, 0, 0); step();
      stop = 1'b1;
      expect_out("up_stop", 0, 0, 0, 0, 0, 0, 0, 0); step();

      // Down-count borrow and expiry.
      mode_down = 1'b1;
      load = 1'b1; load_min = 8'd1; load_sec = 6'd0;
      expect_out("dn_load", 1, 0, 1, 0, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("dn_start", 1, 0, 1, 0, 0, 1, 0, 0); step();
      tick = 1'b1;
      expect_out("dn_borrow", 0, 59, 0, 59, 0, 1, 0, 0); step();
      load = 1'b1; load_min = 8'd0; load_sec = 6'd1; tick = 1'b1;
      expect_out("dn_load_tick", 0, 1, 0, 1, 0, 1, 0, 0); step();
      tick = 1'b1;
      expect_out("dn_expire", 0, 0, 0, 0, 0, 0, 1, 0); step();
      tick = 1'b1;
      expect_out("dn_hold", 0, 0, 0, 0, 0, 0, 1, 0); step();
      start = 1'b1;
      expect_out("dn_start_ign", 0, 0, 0, 0, 0, 0, 1, 0); step();

      // Clamped load out of EXPIRED, then zero-start in down mode.
      load = 1'b1; load_min = 8'd150; load_sec = 6'd63;
      expect_out("clamp", 99, 59, 99, 59, 0, 0, 0, 0); step();
      sync_reset = 1'b1;
      expect_out("srst", 0, 0, 0, 0, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("zero_start", 0, 0, 0, 0, 0, 0, 1, 0); step();
      expect_out("zero_hold", 0, 0, 0, 0, 0, 0, 1, 0); step();

      // Lap freeze with a coincident tick.
      sync_reset = 1'b1; mode_down = 1'b0;
      expect_out("lap_srst", 0, 0, 0, 0, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("lap_start", 0, 0, 0, 0, 0, 1, 0, 0); step();
      for (int i = 1; i <= 5; i++) begin
         tick = 1'b1;
         expect_out($sformatf("lap_run%0d", i), 0, i, 0, i, 0, 1, 0, 0); step();
      end
      lap = 1'b1; tick = 1'b1;
      expect_out("lap_cap", 0, 6, 0, 5, 1, 1, 0, 0); step();
      for (int i = 7; i <= 9; i++) begin
         tick = 1'b1;
         expect_out($sformatf("lap_frz%0d", i), 0, i, 0, 5, 1, 1, 0, 0); step();
      end
      lap = 1'b1;
      expect_out("lap_rel", 0, 9, 0, 9, 0, 1, 0, 0); step();

      // Priority: stop beats start and tick; sync_reset beats load.
      tick = 1'b1;
      expect_out("pri_t10", 0, 10, 0, 10, 0, 1, 0, 0); step();
      stop = 1'b1;
      expect_out("pri_pause", 0, 10, 0, 10, 0, 0, 0, 0); step();
      start = 1'b1; stop = 1'b1; tick = 1'b1;
      expect_out("pri_sst", 0, 10, 0, 10, 0, 0, 0, 0); step();
      sync_reset = 1'b1; load = 1'b1; load_min = 8'd5; load_sec = 6'd5;
      expect_out("pri_srst_ld", 0, 0, 0, 0, 0, 0, 0, 0); step();

      // Asynchronous reset between clock edges while running.
      load = 1'b1; load_min = 8'd12; load_sec = 6'd34;
      expect_out("ar_load", 12, 34, 12, 34, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("ar_run", 12, 34, 12, 34, 0, 1, 0, 0); step();
      #3 rst = 1'b1;
      #1;
      expect_out("ar_async", 0, 0, 0, 0, 0, 0, 0, 0); compare_out();
      #2 rst = 1'b0;
      tick = 1'b1;
      expect_out("ar_tick_ign", 0, 0, 0, 0, 0, 0, 0, 0); step();
      start = 1'b1;
      expect_out("ar_start", 0, 0, 0, 0, 0, 1, 0, 0); step();
      tick = 1'b1;
      expect_out("ar_tick", 0, 1, 0, 1, 0, 1, 0, 0); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
